dmem_dump_ctrl: RTL and testbench
=================================

# dmem_dump_ctrl

Data-memory port arbiter and dump sequencer for the single-cycle LEGv8 processor. Sits between the processor's data-memory interface and the data memory. In normal operation it passes processor accesses through. On a `dump` request it stalls the processor, takes the memory port, and streams every data-memory word out over a valid/ready interface, for testbench inspection or a host link.

## Interface
- `N`, 64: data and address width.
- `DEPTH`, 128: number of 64-bit words in data memory; power of two, ≤ 2^(N-3).
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `dump`  in  1  dump request, level; a dump starts on its rising edge.
- `cpu_addr`  in  N  processor byte address.
- `cpu_writeData`  in  N  processor store data.
- `cpu_writeEnable`  in  1  processor store strobe.
- `cpu_readData`  out  N  load data to processor; always equals `mem_readData`.
- `cpu_stall`  out  1  freezes PC and register-file writes while high.
- `mem_addr`  out  N  byte address to data memory.
- `mem_writeData`  out  N  store data to data memory.
- `mem_writeEnable`  out  1  store strobe to data memory.
- `mem_readData`  in  N  combinational (asynchronous) read data from data memory.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  consumer accepts word.
- `dump_addr`  out  N  byte address of current dump word.
- `dump_data`  out  N  current dump word.
- `dump_done`  out  1  all DEPTH words transferred.

## Operation
- **States:** IDLE, READ, SEND, DONE. Registers: word index `idx` (log2 DEPTH bits), `dump_q` (previous `dump`), `dump_data`.
- **IDLE:**
  - `mem_*` = `cpu_*`; `cpu_stall`=0.
  - If `dump & ~dump_q`: `idx`←0, go to READ.
- **READ:**
  - `mem_addr` = {idx, 3'b000}, zero-extended to N; `mem_writeEnable`=0; `cpu_stall`=1.
  - Latch `mem_readData` into `dump_data`, go to SEND.
- **SEND:**
  - `dump_valid`=1; `dump_addr` = {idx, 3'b000}; `dump_data` stable; `cpu_stall`=1; `mem_writeEnable`=0.
  - On `dump_valid & dump_ready`:
    - `idx`==DEPTH-1: go to DONE.
    - Otherwise: `idx`←`idx`+1, go to READ.
- **DONE:**
  - `dump_done`=1; `cpu_stall`=1; `mem_writeEnable`=0.
  - When `dump`=0, go to IDLE.
- **Boundary and corner cases:**
  - `dump` falling mid-dump does not abort; the sequence runs to completion.
  - `dump` held high in DONE keeps the processor stalled.
  - `idx` never wraps: the last index exits to DONE.
  - `cpu_writeEnable` is ignored (gated) in every state except IDLE.
  - `cpu_readData` passes through in all states; its value is meaningless while stalled.
- **Reset:** synchronous `reset` forces IDLE from any state, including mid-dump, on the next edge.
  - `idx`=0, `dump_q`=0, `dump_data`=0.
  - Outputs: `dump_valid`=0, `dump_done`=0, `cpu_stall`=0, `dump_addr`=0.
  - An undelivered word is dropped.

## Timing
- A rising edge of `dump` sampled at edge k: the processor store in cycle k-1..k completes normally.
- `cpu_stall` goes high after edge k (registered state); the first READ cycle follows edge k.
- Per word: 1 READ cycle + ≥1 SEND cycle. With `dump_ready` tied high, DEPTH words take 2·DEPTH cycles from the first READ to DONE.
- `dump_valid` is registered-state-derived. Once high, `dump_valid`, `dump_addr` and `dump_data` hold stable until the handshake.
- `cpu_stall` falls in the cycle after DONE sees `dump`=0. The processor resumes at the frozen PC.
- All outputs are combinational from state/registers only. The exception is the IDLE pass-through, which is combinational from `cpu_*`.

## Structure
- **Package `dmem_dump_pkg`:**
  - state enum typedef `dump_state_t` {IDLE, READ, SEND, DONE}.
  - constant `WORD_BYTES`=8 and `WORD_SHIFT`=3.
- **Sub-module `dmem_port_mux`:** combinational selection of the `mem_*` sources (processor vs. dump engine) plus write gating. FSM, index counter and edge detect stay in the top module.

## Test plan
- **Pass-through:** in IDLE, store `cpu_addr`=0x18, data 0xDEAD, `cpu_writeEnable`=1 → `mem_addr`=0x18, `mem_writeData`=0xDEAD, `mem_writeEnable`=1, `cpu_stall`=0.
- **Full dump:** DEPTH=4, memory preloaded {0x11,0x22,0x33,0x44}, `dump_ready`=1, pulse `dump` → four handshakes with (`dump_addr`, `dump_data`) = (0,0x11),(8,0x22),(0x10,0x33),(0x18,0x44). `dump_done` rises 8 cycles after the first READ.
- **Backpressure:** `dump_ready`=0 for 5 cycles during word 1 → `dump_valid`, `dump_addr`=8 and `dump_data`=0x22 stay stable. Word 1 is not repeated or skipped.
- **Write blocking:** `cpu_writeEnable`=1 at addr 0 throughout a dump → `mem_writeEnable`=0 in READ/SEND/DONE. Memory word 0 is still 0x11 afterwards.
- **Reset mid-dump:** assert `reset` in SEND of word 2 → next cycle `dump_valid`=0, `cpu_stall`=0, `dump_done`=0. A new `dump` edge restarts at `dump_addr`=0.
- **Release:** hold `dump`=1 after DONE → `cpu_stall` stays 1. Drop `dump` → `cpu_stall`=0 one cycle later; a second dump starts only on a new rising edge.

Source files
------------

// File: rtl/dmem_dump_pkg.sv
// Shared types and constants for the data-memory dump controller.
// Word size is fixed at 8 bytes, which is why addresses are word index << 3.
package dmem_dump_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SEND,
      DONE
   } dump_state_t;

   localparam int WORD_BYTES = 8;
   localparam int WORD_SHIFT = 3;

endpackage

// File: rtl/dmem_dump_ctrl_if.sv
// Dump word stream: valid/ready handshake plus the completion flag.
// The engine drives it through the master modport; a consumer uses the slave one.
interface dmem_dump_ctrl_if #(
   parameter int N = 64
);

   logic         dump_valid;
   logic         dump_ready;
   logic [N-1:0] dump_addr;
   logic [N-1:0] dump_data;
   logic         dump_done;

   modport master (
      output dump_valid,
      input  dump_ready,
      output dump_addr,
      output dump_data,
      output dump_done
   );

   modport slave (
      input  dump_valid,
      output dump_ready,
      input  dump_addr,
      input  dump_data,
      input  dump_done
   );

endinterface

// File: rtl/dmem_port_mux.sv
// Selects who owns the data-memory port: the processor or the dump engine.
// Stores are only let through while the processor owns the port.
module dmem_port_mux #(
   parameter int N = 64
) (
   input  logic         sel_cpu,
   input  logic [N-1:0] cpu_addr,
   input  logic [N-1:0] cpu_wdata,
   input  logic         cpu_we,
   input  logic [N-1:0] eng_addr,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         mem_we
);

   always_comb begin
      mem_addr  = eng_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      if (sel_cpu) begin
         mem_addr = cpu_addr;
         mem_we   = cpu_we;
      end
   end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory arbiter: passes processor accesses through, or on a dump
// request stalls the processor and streams every memory word out.
module dmem_dump_ctrl
   import dmem_dump_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 128
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         dump,
   input  logic [N-1:0] cpu_addr,
   input  logic [N-1:0] cpu_writeData,
   input  logic         cpu_writeEnable,
   output logic [N-1:0] cpu_readData,
   output logic         cpu_stall,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_writeData,
   output logic         mem_writeEnable,
   input  logic [N-1:0] mem_readData,
   dmem_dump_ctrl_if.master dbus
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   dump_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          dump_q, dump_d;
   logic [N-1:0]  dump_data_q, dump_data_d;
   logic [N-1:0]  word_addr;
   logic          dump_rise;

   assign word_addr = N'(idx_q) << WORD_SHIFT;
   assign dump_rise = dump & ~dump_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         dump_q      <= 1'b0;
         dump_data_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dump_q      <= dump_d;
         dump_data_q <= dump_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dump_d      = dump;
      dump_data_d = dump_data_q;
      unique case (state_q)
         IDLE: begin
            if (dump_rise) begin
               idx_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            dump_data_d = mem_readData;
            state_d     = SEND;
         end
         SEND: begin
            if (dbus.dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = READ;
               end
            end
         end
         DONE: begin
            // Stay here, processor stalled, until the request is withdrawn.
            if (!dump) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_stall       = (state_q != IDLE);
      dbus.dump_valid = (state_q == SEND);
      dbus.dump_done  = (state_q == DONE);
      dbus.dump_data  = dump_data_q;
      dbus.dump_addr  = '0;
      if (state_q == SEND) dbus.dump_addr = word_addr;
   end

   assign cpu_readData = mem_readData;

   dmem_port_mux #(
      .N(N)
   ) u_mux (
      .sel_cpu   (state_q == IDLE),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_writeData),
      .cpu_we    (cpu_writeEnable),
      .eng_addr  (word_addr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_writeData),
      .mem_we    (mem_writeEnable)
   );

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl with a 4-word memory model and a dump scoreboard.
// Expected dump words are queued by the stimulus and popped by the monitor.
module tb_dmem_dump_ctrl;

   localparam int N     = 64;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         dump;
   logic [N-1:0] cpu_addr;
   logic [N-1:0] cpu_writeData;
   logic         cpu_writeEnable;
   logic [N-1:0] cpu_readData;
   logic         cpu_stall;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_writeData;
   logic         mem_writeEnable;
   logic [N-1:0] mem_readData;

   logic [N-1:0] mem [DEPTH];

   typedef struct {
      logic [N-1:0] addr;
      logic [N-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   dmem_dump_ctrl_if #(.N(N)) dbus ();

   dmem_dump_ctrl #(
      .N(N),
      .DEPTH(DEPTH)
   ) dut (
      .CLOCK_50        (clk),
      .reset           (reset),
      .dump            (dump),
      .cpu_addr        (cpu_addr),
      .cpu_writeData   (cpu_writeData),
      .cpu_writeEnable (cpu_writeEnable),
      .cpu_readData    (cpu_readData),
      .cpu_stall       (cpu_stall),
      .mem_addr        (mem_addr),
      .mem_writeData   (mem_writeData),
      .mem_writeEnable (mem_writeEnable),
      .mem_readData    (mem_readData),
      .dbus            (dbus)
   );

   always #5 clk = ~clk;

   assign mem_readData = mem[mem_addr[4:3]];

   always @(posedge clk) begin
      if (mem_writeEnable) mem[mem_addr[4:3]] <= mem_writeData;
   end

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_all();
      exp_q.push_back('{64'h00, 64'h11});
      exp_q.push_back('{64'h08, 64'h22});
      exp_q.push_back('{64'h10, 64'h33});
      exp_q.push_back('{64'h18, 64'h44});
   endtask

   task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
      cpu_addr        = a;
      cpu_writeData   = d;
      cpu_writeEnable = 1'b1;
      tick();
      cpu_writeEnable = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cnt);
      cnt = 0;
      while (!dbus.dump_done && cnt < budget) begin
         tick();
         cnt++;
      end
      chk("done_reached", {63'd0, dbus.dump_done}, 64'd1);
   endtask

   always @(negedge clk) begin
      if (!reset && dbus.dump_valid && dbus.dump_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_word: got addr %h data %h expected none",
                     dbus.dump_addr, dbus.dump_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_addr", dbus.dump_addr, e.addr);
            chk("sb_data", dbus.dump_data, e.data);
         end
      end
   end

   initial begin
      int cnt;
      reset           = 1'b1;
      dump            = 1'b0;
      cpu_addr        = '0;
      cpu_writeData   = '0;
      cpu_writeEnable = 1'b0;
      dbus.dump_ready = 1'b0;
      tick();
      tick();
      chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
      chk("rst_valid", {63'd0, dbus.dump_valid}, 64'd0);
      chk("rst_done", {63'd0, dbus.dump_done}, 64'd0);
      chk("rst_addr", dbus.dump_addr, 64'd0);
      chk("rst_data", dbus.dump_data, 64'd0);
      reset = 1'b0;

      cpu_addr        = 64'h18;
      cpu_writeData   = 64'hDEAD;
      cpu_writeEnable = 1'b1;
      #1;
      chk("pt_addr", mem_addr, 64'h18);
      chk("pt_wdata", mem_writeData, 64'hDEAD);
      chk("pt_we", {63'd0, mem_writeEnable}, 64'd1);
      chk("pt_stall", {63'd0, cpu_stall}, 64'd0);
      tick();
      cpu_writeEnable = 1'b0;
      chk("pt_mem", mem[3], 64'hDEAD);

      store(64'h00, 64'h11);
      store(64'h08, 64'h22);
      store(64'h10, 64'h33);
      store(64'h18, 64'h44);

      // Full dump with processor stores attempted to word 0 throughout.
      push_all();
      dbus.dump_ready = 1'b1;
      dump            = 1'b1;
      tick();
      cpu_addr        = 64'h00;
      cpu_writeData   = 64'hBAD;
      cpu_writeEnable = 1'b1;
      cnt = 0;
      while (!dbus.dump_done && cnt < 40) begin
         chk("wb_we", {63'd0, mem_writeEnable}, 64'd0);
         chk("dump_stall", {63'd0, cpu_stall}, 64'd1);
         tick();
         cnt++;
      end
      chk("done_latency", 64'(cnt), 64'd8);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_stall", {63'd0, cpu_stall}, 64'd1);
         chk("hold_done", {63'd0, dbus.dump_done}, 64'd1);
         chk("hold_we", {63'd0, mem_writeEnable}, 64'd0);
      end
      cpu_writeEnable = 1'b0;
      dump            = 1'b0;
      #1;
      chk("rel_stall_pre", {63'd0, cpu_stall}, 64'd1);
      tick();
      chk("rel_stall", {63'd0, cpu_stall}, 64'd0);
      chk("full_q_empty", 64'(exp_q.size()), 64'd0);
      chk("wb_mem0", mem[0], 64'h11);
      tick();
      chk("no_restart", {63'd0, cpu_stall}, 64'd0);

      // Backpressure on word 1; dump falls mid-sequence without aborting.
      push_all();
      dump = 1'b1;
      tick();
      dump = 1'b0;
      tick();
      tick();
      dbus.dump_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {63'd0, dbus.dump_valid}, 64'd1);
         chk("bp_addr", dbus.dump_addr, 64'h08);
         chk("bp_data", dbus.dump_data, 64'h22);
         tick();
      end
      dbus.dump_ready = 1'b1;
      wait_done(40, cnt);
      tick();
      chk("bp_release", {63'd0, cpu_stall}, 64'd0);
      chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

      // Reset while word 2 is waiting in SEND.
      exp_q.push_back('{64'h00, 64'h11});
      exp_q.push_back('{64'h08, 64'h22});
      dump = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      dbus.dump_ready = 1'b0;
      tick();
      chk("rm_valid_pre", {63'd0, dbus.dump_valid}, 64'd1);
      chk("rm_addr_pre", dbus.dump_addr, 64'h10);
      reset = 1'b1;
      dump  = 1'b0;
      tick();
      chk("rm_valid", {63'd0, dbus.dump_valid}, 64'd0);
      chk("rm_stall", {63'd0, cpu_stall}, 64'd0);
      chk("rm_done", {63'd0, dbus.dump_done}, 64'd0);
      chk("rm_q_empty", 64'(exp_q.size()), 64'd0);
      reset = 1'b0;
      tick();

      push_all();
      dbus.dump_ready = 1'b1;
      dump            = 1'b1;
      tick();
      tick();
      chk("rs_addr", dbus.dump_addr, 64'h00);
      wait_done(40, cnt);
      dump = 1'b0;
      tick();
      chk("rs_q_empty", 64'(exp_q.size()), 64'd0);
      chk("rs_stall", {63'd0, cpu_stall}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
